imem_loader: RTL

- Write-side companion to the byte-addressed, little-endian instruction memory. The memory is read combinationally as {Mem[a+3], Mem[a+2], Mem[a+1], Mem[a]}.
- Accepts 32-bit instruction words over a valid/ready stream and writes them one byte per cycle through the memory's byte-wide write port.
- Asserts a hold to the pipeline while loading, so programs can be loaded at run time instead of only by file preload.

---
 rtl/imem_loader.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: streams 32-bit instruction words into a byte-wide,
// little-endian instruction memory, one byte per cycle, low byte first.
// The pipeline is held (busy) while a load is in flight.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle load request (sampled in IDLE only)
//   base_addr[AW]       byte start address, word-aligned on capture
//   word_count[CW]      number of words to load (0 completes at once)
//   in_valid/in_data    word stream in; in_ready accepts a word
//   mem_we/mem_addr/mem_wdata   byte write port toward the memory
//   busy                pipeline hold while loading
//   done                one-cycle completion pulse
//   checksum[8]         (IMEM_LOADER_CHECKSUM_EN only) mod-256 sum of the
//                       bytes written since the last accepted start
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN

module imem_loader #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8,
    parameter int unsigned CW    = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [CW-1:0] word_count,
    input  logic          in_valid,
    input  logic [31:0]   in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          busy,
`ifdef IMEM_LOADER_CHECKSUM_EN
    output logic [7:0]    checksum,
`endif
    output logic          done
);

    localparam logic [AW-1:0] ADDR_MASK  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ALIGN_MASK = ~AW'(3);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    idx_q;
    logic [31:0]   word_q;
    logic [7:0]    byte_c;

    // Byte of the held word selected by the current byte index
    assign byte_c = 8'(word_q >> {idx_q, 3'b000});

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (word_count == '0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (in_valid) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (idx_q == 2'd3) begin
                    state_d = (cnt_q == CW'(1)) ? S_DONE : S_WAIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from registered state and datapath only
    always_comb begin
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_WAIT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = byte_c;
                busy      = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Address, remaining count, byte index and word holding register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            cnt_q  <= '0;
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && (word_count != '0)) begin
                        addr_q <= base_addr & ALIGN_MASK;
                        cnt_q  <= word_count;
                    end
                end
                S_WAIT: begin
                    if (in_valid) begin
                        word_q <= in_data;
                        idx_q  <= '0;
                    end
                end
                S_WRITE: begin
                    // Address wraps modulo DEPTH; oversized loads overwrite silently
                    addr_q <= (addr_q + AW'(1)) & ADDR_MASK;
                    idx_q  <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    addr_q <= addr_q;
                end
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running byte sum; cleared by any accepted start, held after completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            checksum <= '0;
        end else if (state_q == S_WRITE) begin
            checksum <= checksum + byte_c;
        end
    end
`endif

endmodule
